// File: rtl/decimal_converter_if.sv
// Divider bus between decimal_converter (master) and the shared Divider (slave).
// Signal names are written from the converter's point of view.
interface decimal_converter_if #(
  parameter int N = 8
);
  logic         o_div_start;
  logic [N-1:0] o_div_dividend;
  logic [N-1:0] o_div_divisor;
  logic         i_div_finished;
  logic [N-1:0] i_div_quotient;
  logic [N-1:0] i_div_remainder;
  logic         i_div_divide_by_zero;

  modport master (
    output o_div_start, o_div_dividend, o_div_divisor,
    input  i_div_finished, i_div_quotient, i_div_remainder, i_div_divide_by_zero
  );

  modport slave (
    input  o_div_start, o_div_dividend, o_div_divisor,
    output i_div_finished, i_div_quotient, i_div_remainder, i_div_divide_by_zero
  );
endinterface

// File: rtl/decimal_converter.sv
// Binary to packed BCD converter. Peels one decimal digit per Divider
// operation (value / 10), least significant digit first, and stops early
// once the working value reaches zero.
module decimal_converter #(
  parameter int N = 8,
  parameter int D = 3
) (
  input  logic           i_clock,
  input  logic           i_reset,
  input  logic           i_start,
  input  logic [N-1:0]   i_value,
  output logic           o_busy,
  output logic           o_finished,
  output logic [4*D-1:0] o_bcd,
  output logic           o_overflow,
  output logic           o_fault,
  decimal_converter_if.master div
);

  // idx must be able to hold D itself, not just D-1
  localparam int IW = $clog2(D + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [N-1:0]   r_work;
  logic [IW-1:0]  r_idx;
  logic [4*D-1:0] r_bcd;
  logic           r_overflow;
  logic           r_fault;
  logic           w_check_done;
  logic           w_unused_rem;

  // Only the low nibble of the remainder can be a decimal digit
  assign w_unused_rem = ^div.i_div_remainder[N-1:4];

  assign w_check_done = (r_work == '0) || (r_idx == IW'(D));

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_CHECK;
      S_CHECK: w_next = w_check_done ? S_DONE : S_ISSUE;
      S_ISSUE: w_next = S_ARM;
      // A finished level left over from the previous op is skipped here
      S_ARM:   w_next = S_WAIT;
      S_WAIT: begin
        if (div.i_div_finished)
          w_next = div.i_div_divide_by_zero ? S_DONE : S_CHECK;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Working value, digit index and result registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_work     <= '0;
      r_idx      <= '0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_work     <= i_value;
            r_idx      <= '0;
            r_bcd      <= '0;
            r_overflow <= 1'b0;
            r_fault    <= 1'b0;
          end
        end
        S_CHECK: begin
          // Digits ran out while value is still nonzero: too big for D digits
          if (w_check_done) r_overflow <= (r_work != '0);
        end
        S_WAIT: begin
          if (div.i_div_finished) begin
            if (div.i_div_divide_by_zero) begin
              r_fault <= 1'b1;
            end else begin
              for (int k = 0; k < D; k++)
                if (r_idx == IW'(k)) r_bcd[4*k +: 4] <= div.i_div_remainder[3:0];
              r_work <= div.i_div_quotient;
              r_idx  <= r_idx + IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy             = (r_state != S_IDLE);
  assign o_finished         = (r_state == S_DONE);
  assign o_bcd              = r_bcd;
  assign o_overflow         = r_overflow;
  assign o_fault            = r_fault;
  assign div.o_div_start    = (r_state == S_ISSUE);
  // r_work only changes on leaving WAIT, so the dividend is stable ISSUE..WAIT
  assign div.o_div_dividend = r_work;
  assign div.o_div_divisor  = N'(10);

endmodule

// File: tb/tb_decimal_converter.sv
// Self-checking bench for decimal_converter: an 8-bit/3-digit instance and a
// 10-bit/3-digit instance, each attached to a behavioural Divider model.
module tb_decimal_converter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- instance A: N=8, D=3 ----------------
  logic        start_a = 1'b0;
  logic [7:0]  va = '0;
  logic        busy_a, fin_a, ovf_a, flt_a;
  logic [11:0] bcd_a;

  decimal_converter_if #(.N(8)) ifa ();

  decimal_converter #(.N(8), .D(3)) dut_a (
    .i_clock(clk), .i_reset(rst), .i_start(start_a), .i_value(va),
    .o_busy(busy_a), .o_finished(fin_a), .o_bcd(bcd_a),
    .o_overflow(ovf_a), .o_fault(flt_a), .div(ifa.master)
  );

  // ---------------- instance B: N=10, D=3 ----------------
  logic        start_b = 1'b0;
  logic [9:0]  vb = '0;
  logic        busy_b, fin_b, ovf_b, flt_b;
  logic [11:0] bcd_b;

  decimal_converter_if #(.N(10)) ifb ();

  decimal_converter #(.N(10), .D(3)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_start(start_b), .i_value(vb),
    .o_busy(busy_b), .o_finished(fin_b), .o_bcd(bcd_b),
    .o_overflow(ovf_b), .o_fault(flt_b), .div(ifb.master)
  );

  // Divider model A. lat_a = L (0 picks 1..4 at random per op): finished
  // rises L edges after the edge that samples start, i.e. L-1 WAIT cycles
  // with finished low. The previous finished level lingers one cycle after
  // the start pulse (allowed by the Divider contract).
  int         lat_a = 0;
  bit         dbz_a = 1'b0;
  int         ops_a = 0;
  int         cnt_a = 0;
  bit         pend_a = 1'b0;
  logic       fa = 1'b0, za = 1'b0, nz_a = 1'b0;
  logic [7:0] qa = '0, ra = '0, nq_a = '0, nr_a = '0;

  assign ifa.i_div_finished       = fa;
  assign ifa.i_div_quotient       = qa;
  assign ifa.i_div_remainder      = ra;
  assign ifa.i_div_divide_by_zero = za;

  // Divider A behaviour
  always @(posedge clk) begin
    if (ifa.o_div_start) begin
      ops_a  <= ops_a + 1;
      pend_a <= 1'b1;
      cnt_a  <= (lat_a > 0) ? lat_a : int'($urandom_range(1, 4));
      if (dbz_a || ifa.o_div_divisor == 0) begin
        nz_a <= 1'b1; nq_a <= '0; nr_a <= '0;
      end else begin
        nz_a <= 1'b0;
        nq_a <= ifa.o_div_dividend / ifa.o_div_divisor;
        nr_a <= ifa.o_div_dividend % ifa.o_div_divisor;
      end
    end else begin
      if (pend_a) begin pend_a <= 1'b0; fa <= 1'b0; end
      if (cnt_a == 1) begin fa <= 1'b1; qa <= nq_a; ra <= nr_a; za <= nz_a; end
      if (cnt_a > 0) cnt_a <= cnt_a - 1;
    end
  end

  // Divider model B: fixed latency 1, same stale-finished behaviour
  int         ops_b = 0;
  int         cnt_b = 0;
  bit         pend_b = 1'b0;
  logic       fb = 1'b0, zb = 1'b0, nz_b = 1'b0;
  logic [9:0] qb = '0, rb = '0, nq_b = '0, nr_b = '0;

  assign ifb.i_div_finished       = fb;
  assign ifb.i_div_quotient       = qb;
  assign ifb.i_div_remainder      = rb;
  assign ifb.i_div_divide_by_zero = zb;

  // Divider B behaviour
  always @(posedge clk) begin
    if (ifb.o_div_start) begin
      ops_b  <= ops_b + 1;
      pend_b <= 1'b1;
      cnt_b  <= 1;
      if (ifb.o_div_divisor == 0) begin
        nz_b <= 1'b1; nq_b <= '0; nr_b <= '0;
      end else begin
        nz_b <= 1'b0;
        nq_b <= ifb.o_div_dividend / ifb.o_div_divisor;
        nr_b <= ifb.o_div_dividend % ifb.o_div_divisor;
      end
    end else begin
      if (pend_b) begin pend_b <= 1'b0; fb <= 1'b0; end
      if (cnt_b == 1) begin fb <= 1'b1; qb <= nq_b; rb <= nr_b; zb <= nz_b; end
      if (cnt_b > 0) cnt_b <= cnt_b - 1;
    end
  end

  // ---------------- reference model ----------------
  // Low three decimal digits of v
  function automatic logic [11:0] ref_bcd(input int v);
    logic [11:0] r;
    int t;
    r = '0;
    t = v % 1000;
    for (int k = 0; k < 3; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Number of divisions: one per significant digit, at most three
  function automatic int ref_ops(input int v);
    int n;
    int t;
    n = 0;
    t = v;
    while (t != 0 && n < 3) begin t = t / 10; n++; end
    return n;
  endfunction

  // Clock edges from the start cycle until o_finished is seen
  function automatic int ref_lat(input int v, input int l);
    return 2 + ref_ops(v) * (3 + l);
  endfunction

  // ---------------- drivers ----------------
  task automatic conv_a(input logic [7:0] v, output int lat, output bit to);
    @(negedge clk); start_a = 1'b1; va = v;
    @(posedge clk); lat = 1;
    @(negedge clk); start_a = 1'b0; to = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (fin_a) begin to = 1'b0; break; end
    end
  endtask

  task automatic conv_b(input logic [9:0] v, output bit to);
    @(negedge clk); start_b = 1'b1; vb = v;
    @(negedge clk); start_b = 1'b0; to = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (fin_b) begin to = 1'b0; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy_a, fin_a, ovf_a, flt_a, ifa.o_div_start} !== 5'b0 || bcd_a !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_a: busy/fin/ovf/flt/start=%b bcd=%h, want 00000 000",
               {busy_a, fin_a, ovf_a, flt_a, ifa.o_div_start}, bcd_a);
    end
    n_cmp++;
    if ({busy_b, fin_b, ovf_b, flt_b, ifb.o_div_start} !== 5'b0 || bcd_b !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_b: busy/fin/ovf/flt/start=%b bcd=%h, want 00000 000",
               {busy_b, fin_b, ovf_b, flt_b, ifb.o_div_start}, bcd_b);
    end
    n_cmp++;
    if (ifa.o_div_divisor !== 8'd10) begin
      n_bad++;
      $display("FAIL divisor: got %0d want 10", ifa.o_div_divisor);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_value;
    int lat, o0;
    bit to;
    lat_a = 2;
    o0 = ops_a;
    conv_a(8'd255, lat, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL v255_timeout: no o_finished"); end
    n_cmp++;
    if (bcd_a !== 12'h255 || ovf_a !== 1'b0 || flt_a !== 1'b0) begin
      n_bad++;
      $display("FAIL v255_result: bcd=%h ovf=%b flt=%b want 255 0 0", bcd_a, ovf_a, flt_a);
    end
    n_cmp++;
    if (ops_a - o0 !== 3) begin n_bad++; $display("FAIL v255_ops: got %0d want 3", ops_a - o0); end
    n_cmp++;
    if (lat !== ref_lat(255, 2)) begin
      n_bad++;
      $display("FAIL v255_latency: got %0d want %0d", lat, ref_lat(255, 2));
    end
    @(negedge clk);
    n_cmp++;
    if (fin_a !== 1'b0 || busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL v255_pulse: fin=%b busy=%b want 0 0", fin_a, busy_a);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (bcd_a !== 12'h255) begin n_bad++; $display("FAIL v255_hold: bcd=%h want 255", bcd_a); end
  endtask

  task automatic test_zero;
    int lat, o0;
    bit to;
    o0 = ops_a;
    conv_a(8'd0, lat, to);
    n_cmp++;
    if (to || lat !== 2) begin
      n_bad++;
      $display("FAIL zero_latency: got %0d (timeout=%0b) want 2", lat, to);
    end
    n_cmp++;
    if (bcd_a !== 12'h000 || ovf_a !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_result: bcd=%h ovf=%b want 000 0", bcd_a, ovf_a);
    end
    n_cmp++;
    if (ops_a !== o0) begin n_bad++; $display("FAIL zero_ops: got %0d want 0", ops_a - o0); end
  endtask

  task automatic test_start_while_busy;
    int lat, o0;
    bit to;
    lat_a = 3;
    o0 = ops_a;
    @(negedge clk); start_a = 1'b1; va = 8'd7;
    @(posedge clk); lat = 1;
    @(negedge clk); start_a = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 300; i++) begin
      // second start request while busy must be dropped
      if (i == 2) begin start_a = 1'b1; va = 8'd99; end
      if (i == 3) start_a = 1'b0;
      @(posedge clk); lat++;
      @(negedge clk);
      if (fin_a) begin to = 1'b0; break; end
    end
    start_a = 1'b0;
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL v7_timeout: no o_finished"); end
    n_cmp++;
    if (bcd_a !== 12'h007) begin n_bad++; $display("FAIL v7_result: bcd=%h want 007", bcd_a); end
    n_cmp++;
    if (lat !== ref_lat(7, 3)) begin
      n_bad++;
      $display("FAIL v7_latency: got %0d want %0d", lat, ref_lat(7, 3));
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ops_a - o0 !== 1 || busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL v7_ops: ops=%0d busy=%b want 1 0", ops_a - o0, busy_a);
    end
  endtask

  task automatic test_random_a;
    int lat, o0, v;
    bit to;
    lat_a = 0;
    for (int n = 0; n < 20; n++) begin
      v  = int'($urandom_range(0, 255));
      o0 = ops_a;
      conv_a(8'(v), lat, to);
      n_cmp++;
      if (to || bcd_a !== ref_bcd(v) || ovf_a !== 1'b0 || flt_a !== 1'b0) begin
        n_bad++;
        $display("FAIL rand_a v=%0d: bcd=%h ovf=%b flt=%b to=%0b want %h 0 0 0",
                 v, bcd_a, ovf_a, flt_a, to, ref_bcd(v));
      end
      n_cmp++;
      if (ops_a - o0 !== ref_ops(v)) begin
        n_bad++;
        $display("FAIL rand_a_ops v=%0d: got %0d want %0d", v, ops_a - o0, ref_ops(v));
      end
    end
  endtask

  task automatic test_overflow;
    bit to;
    int o0, v;
    int vals[6] = '{1000, 999, 1023, 0, 100, 10};
    for (int n = 0; n < 16; n++) begin
      v  = (n < 6) ? vals[n] : int'($urandom_range(0, 1023));
      o0 = ops_b;
      conv_b(10'(v), to);
      n_cmp++;
      if (to || bcd_b !== ref_bcd(v) || ovf_b !== (v >= 1000) || flt_b !== 1'b0) begin
        n_bad++;
        $display("FAIL ovf_b v=%0d: bcd=%h ovf=%b flt=%b to=%0b want %h %0b 0 0",
                 v, bcd_b, ovf_b, flt_b, to, ref_bcd(v), (v >= 1000));
      end
      n_cmp++;
      if (ops_b - o0 !== ref_ops(v)) begin
        n_bad++;
        $display("FAIL ovf_b_ops v=%0d: got %0d want %0d", v, ops_b - o0, ref_ops(v));
      end
    end
  endtask

  task automatic test_fault;
    int lat;
    bit to;
    lat_a = 2;
    dbz_a = 1'b1;
    conv_a(8'd123, lat, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL fault_timeout: no o_finished"); end
    n_cmp++;
    if (flt_a !== 1'b1 || bcd_a !== 12'h000 || ovf_a !== 1'b0) begin
      n_bad++;
      $display("FAIL fault_flags: flt=%b bcd=%h ovf=%b want 1 000 0", flt_a, bcd_a, ovf_a);
    end
    @(negedge clk);
    n_cmp++;
    if (busy_a !== 1'b0 || fin_a !== 1'b0) begin
      n_bad++;
      $display("FAIL fault_idle: busy=%b fin=%b want 0 0", busy_a, fin_a);
    end
    dbz_a = 1'b0;
    conv_a(8'd5, lat, to);
    n_cmp++;
    if (to || flt_a !== 1'b0 || bcd_a !== 12'h005) begin
      n_bad++;
      $display("FAIL fault_clear: flt=%b bcd=%h to=%0b want 0 005 0", flt_a, bcd_a, to);
    end
  endtask

  task automatic test_reset_mid;
    int lat, o0;
    bit to, seen;
    lat_a = 4;
    o0 = ops_a;
    @(negedge clk); start_a = 1'b1; va = 8'd200;
    @(negedge clk); start_a = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ops_a != o0) begin to = 1'b0; break; end
    end
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL rstmid_issue: no Divider start seen"); end
    // one more edge moves ARM -> WAIT
    @(negedge clk);
    n_cmp++;
    if (busy_a !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy: busy=%b want 1", busy_a); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy_a, fin_a, ovf_a, flt_a, ifa.o_div_start} !== 5'b0 || bcd_a !== 12'h000) begin
      n_bad++;
      $display("FAIL rstmid_state: busy/fin/ovf/flt/start=%b bcd=%h want 00000 000",
               {busy_a, fin_a, ovf_a, flt_a, ifa.o_div_start}, bcd_a);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fin_a || busy_a) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin n_bad++; $display("FAIL rstmid_quiet: finished/busy seen after reset, want none"); end
    conv_a(8'd42, lat, to);
    n_cmp++;
    if (to || bcd_a !== 12'h042) begin
      n_bad++;
      $display("FAIL rstmid_after: bcd=%h to=%0b want 042 0", bcd_a, to);
    end
  endtask

  initial begin
    test_reset();
    test_full_value();
    test_zero();
    test_start_while_busy();
    test_random_a();
    test_overflow();
    test_fault();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
